// File: rtl/softmax_seq_ctrl_if.sv
// softmax_seq_ctrl_if: element streams plus softmax_approx datapath bus seen by the sequencer
interface softmax_seq_ctrl_if #(
    parameter int N = 64
);
    logic [1:0]      cfg_mode;
    logic            s_valid;
    logic            s_ready;
    logic [15:0]     s_data;
    logic            m_valid;
    logic            m_ready;
    logic [15:0]     m_data;
    logic            m_last;
    logic            sm_valid_in;
    logic [N*16-1:0] sm_in_x_flat;
    logic [1:0]      sm_length_mode;
    logic            sm_en;
    logic            sm_valid_out;
    logic [N*16-1:0] sm_prob_flat;
    logic            busy;
    logic            err;

    modport master (
        input  cfg_mode, s_valid, s_data, m_ready, sm_valid_out, sm_prob_flat,
        output s_ready, m_valid, m_data, m_last, sm_valid_in, sm_in_x_flat,
               sm_length_mode, sm_en, busy, err
    );

    modport slave (
        output cfg_mode, s_valid, s_data, m_ready, sm_valid_out, sm_prob_flat,
        input  s_ready, m_valid, m_data, m_last, sm_valid_in, sm_in_x_flat,
               sm_length_mode, sm_en, busy, err
    );
endinterface

// File: rtl/softmax_seq_ctrl.sv
// softmax_seq_ctrl: loads a vector into softmax_approx, fires it, streams results; SOFTMAX_SEQ_TIMEOUT_EN adds a WAIT watchdog
module softmax_seq_ctrl #(
    parameter int N       = 64,
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic rst,
    softmax_seq_ctrl_if.master io
);
    localparam int LW = $clog2(N);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, DRAIN} state_t;

    state_t          state, nxt;
    logic [1:0]      mode;
    logic [LW-1:0]   cnt, idx;
    logic [WW-1:0]   wcnt;
    logic            s_ready_q, to_hit, acc;
    logic [N*16-1:0] x_buf, r_buf;

    function automatic logic [LW-1:0] lenm1(input logic [1:0] md);
        return LW'((N >> (3 - int'(md))) - 1);
    endfunction

`ifdef SOFTMAX_SEQ_TIMEOUT_EN
    logic err_q;
    assign to_hit = state == WAIT && !io.sm_valid_out && wcnt == WW'(TIMEOUT - 1);
    always_ff @(posedge clk) err_q <= rst ? 1'b0 : (err_q | to_hit);
    assign io.err = err_q;
`else
    assign to_hit = 1'b0;
    assign io.err = 1'b0;
`endif

    assign acc = io.s_valid && s_ready_q;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (acc) nxt = lenm1(io.cfg_mode) == '0 ? FIRE : LOAD;
            LOAD:    if (acc && cnt == lenm1(mode)) nxt = FIRE;
            FIRE:    nxt = WAIT;
            WAIT:    nxt = io.sm_valid_out ? DRAIN : (to_hit ? IDLE : WAIT);
            DRAIN:   if (io.m_ready && idx == lenm1(mode)) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s_ready_q <= 1'b0;
            mode      <= '0;
            cnt       <= '0;
            idx       <= '0;
            wcnt      <= '0;
            x_buf     <= '0;
            r_buf     <= '0;
        end else begin
            state     <= nxt;
            s_ready_q <= nxt == IDLE || nxt == LOAD;
            wcnt      <= state == WAIT ? wcnt + WW'(1) : '0;
            if (state == IDLE && acc) begin
                mode  <= io.cfg_mode;
                x_buf <= {{(N*16-16){1'b0}}, io.s_data};
                cnt   <= LW'(1);
            end
            if (state == LOAD && acc) begin
                x_buf[16*cnt +: 16] <= io.s_data;
                cnt                 <= cnt + LW'(1);
            end
            if (state == WAIT && io.sm_valid_out) begin
                r_buf <= io.sm_prob_flat;
                idx   <= '0;
            end
            if (state == DRAIN && io.m_ready) idx <= idx + LW'(1);
        end
    end

    assign io.s_ready        = s_ready_q;
    assign io.busy           = state != IDLE;
    assign io.sm_valid_in    = state == FIRE;
    assign io.sm_en          = state == FIRE || state == WAIT;
    assign io.sm_in_x_flat   = x_buf;
    assign io.sm_length_mode = mode;
    assign io.m_valid        = state == DRAIN;
    assign io.m_data         = state == DRAIN ? r_buf[16*idx +: 16] : 16'h0;
    assign io.m_last         = state == DRAIN && idx == lenm1(mode);
endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// tb_softmax_seq_ctrl: directed bench with a 5-cycle datapath model returning lane i = i+1
module tb_softmax_seq_ctrl;
    localparam int N = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    softmax_seq_ctrl_if #(.N(N)) bus ();
    softmax_seq_ctrl #(.N(N), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .io(bus));

    int errors = 0;
    int checks = 0;
    logic dp_en = 1'b1;
    logic dp_v = 1'b0;
    logic spur = 1'b0;
    int dly = 0;
    logic [N*16-1:0] dp_prob;

    assign bus.sm_valid_out = dp_v | spur;
    assign bus.sm_prob_flat = spur ? {N{16'hdead}} : dp_prob;

    always @(posedge clk) begin
        dp_v <= dp_en && dly == 1;
        if (bus.sm_valid_in) dly <= 5;
        else if (dly > 0) dly <= dly - 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lane(input int i);
        return bus.sm_in_x_flat[16*i +: 16];
    endfunction

    task automatic load(input logic [1:0] md, input int n, input logic [15:0] base, input int spur_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("s_ready_load", 32'(bus.s_ready), 1);
            bus.cfg_mode = i == 0 ? md : ~md;
            bus.s_valid  = 1'b1;
            bus.s_data   = base + 16'(i);
            spur         = i == spur_at;
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        spur        = 1'b0;
    endtask

    task automatic drain(input int n, input bit toggle, input int spur_at);
        int e = 0;
        bit r = 1'b1;
        for (int t = 0; t < 40 && !bus.m_valid; t++) @(negedge clk);
        chk("m_valid_rise", 32'(bus.m_valid), 1);
        for (int c = 0; c < 4 * n && e < n; c++) begin
            chk("m_valid", 32'(bus.m_valid), 1);
            chk("m_data", 32'(bus.m_data), 32'(e + 1));
            chk("m_last", 32'(bus.m_last), 32'(e == n - 1));
            bus.m_ready = r;
            spur        = c == spur_at;
            if (r) e++;
            if (toggle) r = !r;
            @(negedge clk);
        end
        bus.m_ready = 1'b0;
        spur        = 1'b0;
        chk("drain_count", 32'(e), 32'(n));
        chk("busy_after", 32'(bus.busy), 0);
        chk("s_ready_after", 32'(bus.s_ready), 1);
        chk("m_valid_after", 32'(bus.m_valid), 0);
        chk("sm_en_after", 32'(bus.sm_en), 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) dp_prob[16*i +: 16] = 16'(i + 1);
        bus.s_valid  = 1'b0;
        bus.s_data   = 16'h0;
        bus.cfg_mode = 2'd0;
        bus.m_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 32'(bus.s_ready), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_sm_en", 32'(bus.sm_en), 0);
        chk("rst_valid_in", 32'(bus.sm_valid_in), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_lane0", 32'(lane(0)), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", 32'(bus.s_ready), 1);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_len_mode", 32'(bus.sm_length_mode), 0);

        // mode 0: 8 elements, then a single FIRE pulse
        load(2'd0, 8, 16'h0100, -1);
        chk("fire_valid_in", 32'(bus.sm_valid_in), 1);
        chk("fire_en", 32'(bus.sm_en), 1);
        chk("fire_s_ready", 32'(bus.s_ready), 0);
        chk("fire_busy", 32'(bus.busy), 1);
        chk("fire_len_mode", 32'(bus.sm_length_mode), 0);
        for (int i = 0; i < N; i++)
            chk("m0_lane", 32'(lane(i)), i < 8 ? 32'(16'h0100 + 16'(i)) : 0);
        @(negedge clk);
        chk("wait_valid_in", 32'(bus.sm_valid_in), 0);
        chk("wait_en", 32'(bus.sm_en), 1);
        drain(8, 1'b0, 3);

        // mode 3 with m_ready toggling and a stray sm_valid_out during LOAD
        load(2'd3, 64, 16'h2000, 10);
        chk("m3_len_mode", 32'(bus.sm_length_mode), 3);
        chk("m3_lane0", 32'(lane(0)), 32'h2000);
        chk("m3_lane63", 32'(lane(63)), 32'h203f);
        chk("m3_valid_in", 32'(bus.sm_valid_in), 1);
        drain(64, 1'b1, -1);

        // reset after 5 of 16 elements discards the partial frame
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.cfg_mode = 2'd1;
            bus.s_valid  = 1'b1;
            bus.s_data   = 16'h5000 + 16'(i);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk("midload_busy", 32'(bus.busy), 1);
        chk("midload_lane4", 32'(lane(4)), 32'h5004);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_lane0", 32'(lane(0)), 0);
        chk("mrst_lane4", 32'(lane(4)), 0);
        chk("mrst_len_mode", 32'(bus.sm_length_mode), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_s_ready", 32'(bus.s_ready), 1);
        load(2'd1, 16, 16'h3000, -1);
        chk("m1_len_mode", 32'(bus.sm_length_mode), 1);
        chk("m1_lane15", 32'(lane(15)), 32'h300f);
        chk("m1_lane16", 32'(lane(16)), 0);
        drain(16, 1'b0, -1);

`ifdef SOFTMAX_SEQ_TIMEOUT_EN
        dp_en = 1'b0;
        load(2'd0, 8, 16'h0400, -1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("to_wait_en", 32'(bus.sm_en), 1);
            chk("to_err_low", 32'(bus.err), 0);
        end
        @(negedge clk);
        chk("to_err", 32'(bus.err), 1);
        chk("to_sm_en", 32'(bus.sm_en), 0);
        chk("to_busy", 32'(bus.busy), 0);
        chk("to_s_ready", 32'(bus.s_ready), 1);
        chk("to_m_valid", 32'(bus.m_valid), 0);
        dp_en = 1'b1;
        load(2'd2, 32, 16'h0600, -1);
        drain(32, 1'b0, -1);
        chk("to_err_sticky", 32'(bus.err), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/softmax_seq_ctrl.md
Name: softmax_seq_ctrl

Overview:
Sequencer that sits between a 16-bit element stream (host/DMA side) and the softmax_approx datapath. It gathers one vector of 8/16/32/64 elements into the N*16 flat input bus and fires the datapath with a one-cycle valid_in pulse. It waits for valid_out, then streams the probabilities back out element by element with a valid/ready handshake. It replaces the free-running stimulus FSM in the top level for real traffic.

Parameters:
N, 64, number of datapath lanes; must be a power of two, at least 8.
TIMEOUT, 1024, max cycles in WAIT before the watchdog fires (used only with SOFTMAX_SEQ_TIMEOUT_EN).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
cfg_mode  input  2  vector length select; sampled on the first element of each frame
s_valid  input  1  input element valid
s_ready  output  1  controller can accept an element
s_data  input  16  input element (Q-format as used by softmax_approx)
m_valid  output  1  output probability valid
m_ready  input  1  downstream accepts output
m_data  output  16  output probability
m_last  output  1  marks the final element of the frame
sm_valid_in  output  1  to softmax_approx valid_in
sm_in_x_flat  output  N*16  to softmax_approx in_x_flat; lane i is bits [16i+15:16i]
sm_length_mode  output  2  to softmax_approx length_mode
sm_en  output  1  to softmax_approx en
sm_valid_out  input  1  from softmax_approx valid_out
sm_prob_flat  input  N*16  from softmax_approx prob_flat
busy  output  1  high in any state other than IDLE
err  output  1  sticky watchdog error flag

Behaviour:
- Length: len = N >> (3 - mode), where mode is the latched cfg_mode. With N=64: 0→8, 1→16, 2→32, 3→64.
- States: IDLE, LOAD, FIRE, WAIT, DRAIN. All outputs decode from registers only; there are no combinational paths from inputs to outputs.
- Reset (sync, rst=1 at a clk edge):
  - State goes to IDLE from any state, including mid-frame; any partial frame is discarded.
  - All counters, sm_in_x_flat, the result buffer and sm_length_mode clear to 0.
  - All outputs are 0 except s_ready, which rises with IDLE in the cycle after reset is released.
  - err clears only on rst.
- IDLE:
  - s_ready=1.
  - On s_valid: latch mode from cfg_mode, drive sm_length_mode=mode, clear all lanes, write s_data to lane 0, set cnt=1, go to LOAD.
- LOAD:
  - s_ready=1. Each accepted element is written to lane cnt, then cnt increments.
  - When the element at lane len-1 is accepted, s_ready drops and the next state is FIRE.
  - Lanes at or above len stay 0. cfg_mode changes are ignored mid-frame.
- FIRE:
  - Exactly one cycle with sm_valid_in=1 and sm_en=1.
  - sm_valid_in rises in the cycle after the last input accept.
- WAIT:
  - sm_en=1, sm_valid_in=0, wait counter increments.
  - When sm_valid_out=1: capture sm_prob_flat into the result buffer, set idx=0, go to DRAIN. sm_en drops in the same transition.
- DRAIN:
  - m_valid=1, m_data = result lane idx, m_last = (idx == len-1).
  - On m_ready: idx increments. On the last accept, return to IDLE.
  - m_valid/m_data hold steady while m_ready=0.
  - First m_valid appears the cycle after sm_valid_out is sampled.
- sm_valid_out is ignored outside WAIT. sm_en=0 outside FIRE/WAIT.
- s_ready=0 during FIRE, WAIT and DRAIN. There is no overlap between frames: the next frame's first element is accepted in IDLE at the earliest, one cycle after the final m_last handshake.
- Throughput: one element per cycle in both LOAD and DRAIN when the handshakes are continuously asserted.

Optional Feature:
SOFTMAX_SEQ_TIMEOUT_EN
- Defined: a wait counter of width clog2(TIMEOUT+1) runs in WAIT. If it reaches TIMEOUT without sm_valid_out, the controller:
  - sets err=1 (sticky until rst);
  - drops sm_en;
  - discards the frame with no output;
  - returns to IDLE.
  A sm_valid_out arriving in the same cycle the count reaches TIMEOUT wins: the frame proceeds normally and err is not set.
- Undefined: WAIT holds indefinitely and err is tied to 0.

Test Plan:
- Mode 0, N=64, s_valid continuous with data 0x0100..0x0107 → s_ready falls after 8 accepts; sm_valid_in is a single pulse one cycle later; lanes 8..63 are 0; sm_length_mode=0.
- Datapath model returns prob_flat 5 cycles after valid_in, lane i = i+1, with m_ready held 1 → 8 outputs 0x0001..0x0008, m_last only on the 8th, busy falls the next cycle.
- Mode 3 with m_ready toggled 1/0 → all 64 outputs appear in order; m_data is stable whenever m_ready=0; no element is duplicated or skipped.
- rst asserted mid-LOAD after 5 of 16 elements → next cycle: IDLE, s_ready=1, lanes cleared; a fresh 16-element frame completes correctly.
- Spurious sm_valid_out pulse during LOAD and during DRAIN → ignored; the result buffer is unchanged and the output sequence is unaffected.
- With SOFTMAX_SEQ_TIMEOUT_EN and TIMEOUT=16, the datapath never responds → err=1 and sm_en=0 after 16 WAIT cycles, then IDLE; the following frame with a responsive model completes and err stays 1.
